// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU. Logic and arithmetic ops finish in one cycle; shifts
// by a non-zero amount run on a one-bit-per-cycle serial shifter. Results
// and flags are held in a single output register that is consumed through
// a valid/ready handshake.
//
// Handshake (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   A producer holds its payload stable while valid=1 and ready=0. ready may
//   depend combinationally on the consumer's ready (in_ready follows
//   out_ready), but valid never depends on ready.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   in_valid / in_ready      upstream handshake
//   alu_control_opcode       0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR,
//                            7 XOR, 8 NOR, 9 SLT, 10 LUI, 11-15 illegal
//   operand_a, operand_b     rs value, rt value / immediate (shift source)
//   shamt                    shift amount
//   out_valid / out_ready    downstream handshake
//   result, zero, overflow,  registered result and flags
//   illegal_op
//   state_dbg                current FSM state (0 IDLE, 1 SHIFT)
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int data_width               = 32,
  parameter int alu_control_opcode_width = 4,
  parameter int shamt_width              = 5
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [alu_control_opcode_width-1:0] alu_control_opcode,
  input  logic [data_width-1:0]               operand_a,
  input  logic [data_width-1:0]               operand_b,
  input  logic [shamt_width-1:0]              shamt,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [data_width-1:0]               result,
  output logic                                zero,
  output logic                                overflow,
  output logic                                illegal_op,
  output logic                                state_dbg
);

  typedef logic [alu_control_opcode_width-1:0] op_t;

  localparam op_t OP_SLL = op_t'(0);
  localparam op_t OP_SRL = op_t'(1);
  localparam op_t OP_SRA = op_t'(2);
  localparam op_t OP_ADD = op_t'(3);
  localparam op_t OP_SUB = op_t'(4);
  localparam op_t OP_AND = op_t'(5);
  localparam op_t OP_OR  = op_t'(6);
  localparam op_t OP_XOR = op_t'(7);
  localparam op_t OP_NOR = op_t'(8);
  localparam op_t OP_SLT = op_t'(9);
  localparam op_t OP_LUI = op_t'(10);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state;
  logic [data_width-1:0]  work;
  logic [shamt_width-1:0] cnt;
  op_t                    shift_kind;

  logic                   accept;
  logic                   is_shift;
  logic                   start_shift;
  logic [data_width-1:0]  sum;
  logic [data_width-1:0]  diff;
  logic [data_width-1:0]  alu_result;
  logic                   alu_overflow;
  logic                   alu_illegal;
  logic [data_width-1:0]  work_next;

  // New work is only taken when the result register is free or being
  // drained on the same edge, so a result is never overwritten unconsumed.
  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

  assign is_shift    = (alu_control_opcode == OP_SLL) ||
                       (alu_control_opcode == OP_SRL) ||
                       (alu_control_opcode == OP_SRA);
  // A zero-length shift is just a copy of operand_b and completes at once.
  assign start_shift = accept && is_shift && (shamt != '0);

  assign sum  = operand_a + operand_b;
  assign diff = operand_a - operand_b;

  // Single-cycle datapath.
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    alu_illegal  = 1'b0;
    case (alu_control_opcode)
      OP_SLL, OP_SRL, OP_SRA: alu_result = operand_b;
      OP_ADD: begin
        alu_result   = sum;
        alu_overflow = (operand_a[data_width-1] == operand_b[data_width-1]) &&
                       (sum[data_width-1] != operand_a[data_width-1]);
      end
      OP_SUB: begin
        alu_result   = diff;
        alu_overflow = (operand_a[data_width-1] != operand_b[data_width-1]) &&
                       (diff[data_width-1] != operand_a[data_width-1]);
      end
      OP_AND: alu_result = operand_a & operand_b;
      OP_OR:  alu_result = operand_a | operand_b;
      OP_XOR: alu_result = operand_a ^ operand_b;
      OP_NOR: alu_result = ~(operand_a | operand_b);
      OP_SLT: alu_result = {{(data_width-1){1'b0}},
                            ($signed(operand_a) < $signed(operand_b))};
      OP_LUI: alu_result = operand_b << 16;
      default: alu_illegal = 1'b1;
    endcase
  end

  // One step of the serial shifter.
  always_comb begin
    work_next = work;
    case (shift_kind)
      OP_SLL:  work_next = {work[data_width-2:0], 1'b0};
      OP_SRL:  work_next = {1'b0, work[data_width-1:1]};
      OP_SRA:  work_next = {work[data_width-1], work[data_width-1:1]};
      default: work_next = work;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      result     <= '0;
      zero       <= 1'b1;
      overflow   <= 1'b0;
      illegal_op <= 1'b0;
      cnt        <= '0;
      work       <= '0;
      shift_kind <= OP_SLL;
    end else begin
      // Drain first; a load on the same edge below re-asserts out_valid.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start_shift) begin
            work       <= operand_b;
            cnt        <= shamt;
            shift_kind <= alu_control_opcode;
            state      <= SHIFT;
          end else if (accept) begin
            result     <= alu_result;
            zero       <= (alu_result == '0);
            overflow   <= alu_overflow;
            illegal_op <= alu_illegal;
            out_valid  <= 1'b1;
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt - shamt_width'(1);
          if (cnt == shamt_width'(1)) begin
            result     <= work_next;
            zero       <= (work_next == '0);
            overflow   <= 1'b0;
            illegal_op <= 1'b0;
            out_valid  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed bench for alu_exec_unit. Inputs change 1 ns after each rising
// edge and outputs are checked at that same point, well clear of the edge.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam logic [3:0] OP_SLL = 4'd0;
  localparam logic [3:0] OP_SRL = 4'd1;
  localparam logic [3:0] OP_SRA = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd9;
  localparam logic [3:0] OP_LUI = 4'd10;
  localparam logic [3:0] OP_BAD = 4'd15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control_opcode;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegal_op;
  logic        state_dbg;

  int tests = 0;
  int fails = 0;

  alu_exec_unit dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .alu_control_opcode (alu_control_opcode),
    .operand_a          (operand_a),
    .operand_b          (operand_b),
    .shamt              (shamt),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .result             (result),
    .zero               (zero),
    .overflow           (overflow),
    .illegal_op         (illegal_op),
    .state_dbg          (state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    in_valid           = valid;
    alu_control_opcode = op;
    operand_a          = a;
    operand_b          = b;
    shamt              = sh;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 5'd0);
    out_ready = 1'b1;

    // Reset values
    #1 reset_n = 1'b0;
    #2;
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst result", result, 32'h0);
    check("rst zero", {31'b0, zero}, 32'd1);
    check("rst overflow", {31'b0, overflow}, 32'd0);
    check("rst illegal", {31'b0, illegal_op}, 32'd0);
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    step();
    step();
    reset_n = 1'b1;

    // ADD with signed overflow, one-cycle latency
    drive(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    step();
    check("add out_valid", {31'b0, out_valid}, 32'd1);
    check("add result", result, 32'h8000_0000);
    check("add overflow", {31'b0, overflow}, 32'd1);
    check("add zero", {31'b0, zero}, 32'd0);

    // SUB then SLT back to back
    drive(1'b1, OP_SUB, 32'd5, 32'd5, 5'd0);
    step();
    check("sub result", result, 32'h0);
    check("sub zero", {31'b0, zero}, 32'd1);
    check("sub overflow", {31'b0, overflow}, 32'd0);
    drive(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    step();
    check("slt out_valid", {31'b0, out_valid}, 32'd1);
    check("slt result", result, 32'h1);
    check("slt zero", {31'b0, zero}, 32'd0);

    // SRA by 4; inputs changed during the shift must be ignored
    drive(1'b1, OP_SRA, 32'h1234_5678, 32'h8000_0000, 5'd4);
    step();
    check("sra busy0 in_ready", {31'b0, in_ready}, 32'd0);
    check("sra busy0 out_valid", {31'b0, out_valid}, 32'd0);
    drive(1'b1, OP_ADD, 32'h1, 32'h1, 5'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("sra busy%0d in_ready", i), {31'b0, in_ready}, 32'd0);
      check($sformatf("sra busy%0d out_valid", i), {31'b0, out_valid}, 32'd0);
    end
    step();
    check("sra out_valid", {31'b0, out_valid}, 32'd1);
    check("sra result", result, 32'hF800_0000);
    check("sra in_ready", {31'b0, in_ready}, 32'd1);

    // SRL by 4 of the same operand
    drive(1'b1, OP_SRL, 32'h0, 32'h8000_0000, 5'd4);
    step();
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 5'd0);
    for (int i = 1; i < 4; i++) step();
    check("srl early out_valid", {31'b0, out_valid}, 32'd0);
    step();
    check("srl out_valid", {31'b0, out_valid}, 32'd1);
    check("srl result", result, 32'h0800_0000);

    // Shift by zero completes in a single cycle
    drive(1'b1, OP_SLL, 32'h0, 32'h0000_00A5, 5'd0);
    step();
    check("sll0 out_valid", {31'b0, out_valid}, 32'd1);
    check("sll0 result", result, 32'h0000_00A5);

    // LUI then illegal opcode
    drive(1'b1, OP_LUI, 32'hFFFF_FFFF, 32'h0000_1234, 5'd7);
    step();
    check("lui result", result, 32'h1234_0000);
    check("lui illegal", {31'b0, illegal_op}, 32'd0);
    drive(1'b1, OP_BAD, 32'h1, 32'h2, 5'd3);
    step();
    check("ill result", result, 32'h0);
    check("ill illegal", {31'b0, illegal_op}, 32'd1);
    check("ill zero", {31'b0, zero}, 32'd1);
    check("ill overflow", {31'b0, overflow}, 32'd0);

    // Backpressure: AND result held while out_ready is low
    drive(1'b1, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
    step();
    check("and result", result, 32'hF000_F000);
    out_ready = 1'b0;
    drive(1'b1, OP_OR, 32'h0000_000F, 32'h0000_00F0, 5'd0);
    #1;
    check("bp in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp%0d result", i), result, 32'hF000_F000);
      check($sformatf("bp%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp%0d in_ready", i), {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("or out_valid", {31'b0, out_valid}, 32'd1);
    check("or result", result, 32'h0000_00FF);
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 5'd0);
    step();
    check("drain out_valid", {31'b0, out_valid}, 32'd0);
    check("drain result held", result, 32'h0000_00FF);

    // Reset in the middle of a long shift
    drive(1'b1, OP_SLL, 32'h0, 32'h0000_0001, 5'd20);
    step();
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 6; i++) step();
    reset_n = 1'b0;
    #1;
    check("mid rst out_valid", {31'b0, out_valid}, 32'd0);
    check("mid rst result", result, 32'h0);
    check("mid rst zero", {31'b0, zero}, 32'd1);
    step();
    step();
    reset_n = 1'b1;
    drive(1'b1, OP_ADD, 32'd2, 32'd3, 5'd0);
    step();
    check("post rst out_valid", {31'b0, out_valid}, 32'd1);
    check("post rst add", result, 32'd5);
    drive(1'b0, OP_ADD, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 20; i++) step();
    check("no stale shift out_valid", {31'b0, out_valid}, 32'd0);
    check("no stale shift result", result, 32'd5);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
